// File: rtl/router_merge.sv
// ---------------------------------------------------------------------------
// router_merge
//   4-to-1 merge for the return path of the 4-way address router. Words from
//   four sources are arbitrated round-robin into a single registered output
//   stage with valid/ready backpressure. Each output word carries the 2-bit
//   index of the source it came from.
//
// Ports
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   din0..din3           source data words
//   din_en[3:0]          source i presents a valid word
//   din_ready[3:0]       source i's word is taken this cycle (one-hot or zero)
//   dout, dout_addr      merged word and its source index (zero when empty)
//   dout_en              output stage holds a valid word
//   dout_ready           sink takes dout this cycle
// ---------------------------------------------------------------------------
module router_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic [3:0]            din_en,
    output logic [3:0]            din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_en,
    output logic [1:0]            dout_addr,
    input  logic                  dout_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [3:0][DATA_WIDTH-1:0] din_arr;
    assign din_arr = {din3, din2, din1, din0};

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [1:0]            addr_q, addr_d;
    logic [1:0]            last_q, last_d;

    logic       load, pop, found;
    logic [1:0] grant, cand;

    // Round-robin search starting just after the last granted port; the
    // 2-bit add wraps, so k=4 lands back on 'last' as the final candidate.
    always_comb begin
        grant = last_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && din_en[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // resetn gates load so no source sees a ready pulse while reset is held.
    assign load = resetn & (|din_en) & ((state_q == ST_EMPTY) | dout_ready);
    assign pop  = (state_q == ST_FULL) & dout_ready;

    for (genvar i = 0; i < 4; i++) begin : g_rdy
        assign din_ready[i] = load & (grant == 2'(i));
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        last_d  = last_q;
        if (load) begin
            state_d = ST_FULL;
            dout_d  = din_arr[grant];
            addr_d  = grant;
            last_d  = grant;
        end else if (pop) begin
            // Draining to empty clears the payload so idle outputs read zero.
            state_d = ST_EMPTY;
            dout_d  = '0;
            addr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            dout_q  <= '0;
            addr_q  <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign dout      = dout_q;
    assign dout_addr = addr_q;
    assign dout_en   = (state_q == ST_FULL);

endmodule

// File: tb/tb_router_merge.sv
// ---------------------------------------------------------------------------
// tb_router_merge
//   Self-checking bench for router_merge: directed scenarios followed by a
//   long randomized run. Expected words are queued when a grant is predicted;
//   an independent monitor compares them as the DUT presents output.
// ---------------------------------------------------------------------------
module tb_router_merge;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [DW-1:0] din [4];
    logic [3:0]    din_en;
    logic [3:0]    din_ready;
    logic [DW-1:0] dout;
    logic          dout_en;
    logic [1:0]    dout_addr;
    logic          dout_ready;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DW+1:0] sb [$];
    int            m_last = 3;
    bit            m_full = 1'b0;
    int            skip [4];
    logic [3:0]    acc;
    int            seq [4];

    always #5 clk = ~clk;

    router_merge #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din0      (din[0]),
        .din1      (din[1]),
        .din2      (din[2]),
        .din3      (din[3]),
        .din_en    (din_en),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_en   (dout_en),
        .dout_addr (dout_addr),
        .dout_ready(dout_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_full = 1'b0;
        m_last = 3;
        for (int i = 0; i < 4; i++) skip[i] = 0;
    endtask

    // Monitor: any presented word must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dout_en) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_word", 64'(dout_en), 64'(0));
            end else begin
                chk("mon_word", 64'({dout_addr, dout}), 64'(sb[0]));
                if (dout_ready) void'(sb.pop_front());
            end
        end else begin
            chk("mon_idle_zero", 64'({dout_addr, dout}), 64'(0));
        end
    end

    // One clock: predict the grant from the rules, check the handshake at
    // mid-cycle, then commit the model at the rising edge.
    task automatic step();
        logic [3:0] exp_rdy;
        int         g;
        bit         ld, pp;
        @(negedge clk);
        ld = (resetn === 1'b1) && (din_en != 4'b0) && (!m_full || dout_ready);
        pp = m_full && dout_ready;
        g = -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (g < 0 && din_en[c]) g = c;
        end
        exp_rdy = 4'b0;
        if (ld) exp_rdy[g] = 1'b1;
        chk("din_ready", 64'(din_ready), 64'(exp_rdy));
        chk("dout_en", 64'(dout_en), 64'(m_full));
        if (ld) begin
            for (int i = 0; i < 4; i++) begin
                if (i == g) skip[i] = 0;
                else if (din_en[i]) begin
                    skip[i]++;
                    chk("fairness", 64'(skip[i] <= 3), 64'(1));
                end
            end
        end
        @(posedge clk);
        if (!resetn) model_reset();
        else if (ld) begin
            sb.push_back({2'(g), din[g]});
            m_full = 1'b1;
            m_last = g;
        end else if (pp) m_full = 1'b0;
        acc = exp_rdy;
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        din_en = 4'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        din_en = 4'b0;
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        #1;
        do_reset();
        chk("reset_state", 64'({dout_en, dout_addr, dout}), 64'(0));

        // Single requester out of reset, latency of one cycle
        resetn = 1'b0;
        model_reset();
        din_en = 4'b0100;
        din[2] = 32'hA5A5_0002;
        dout_ready = 1'b1;
        step();
        resetn = 1'b1;
        step();
        chk("t1_dout", 64'(dout), 64'(32'hA5A5_0002));
        chk("t1_addr", 64'(dout_addr), 64'(2));
        chk("t1_en", 64'(dout_en), 64'(1));
        din_en = 4'b0;
        step();

        // All four requesting: strict rotation starting at port 0
        do_reset();
        for (int i = 0; i < 4; i++) din[i] = DW'(i);
        din_en = 4'b1111;
        dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_addr", 64'(dout_addr), 64'(k % 4));
            chk("t2_dout", 64'(dout), 64'(k % 4));
        end
        din_en = 4'b0;
        step();

        // Backpressure while full with port 1 held, then 3 before 0
        do_reset();
        din[1] = 32'h1111_0001;
        din[3] = 32'h3333_0003;
        din[0] = 32'h0000_0F00;
        din_en = 4'b0010;
        dout_ready = 1'b0;
        step();
        din_en = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_hold_dout", 64'(dout), 64'(32'h1111_0001));
            chk("t3_hold_addr", 64'(dout_addr), 64'(1));
        end
        dout_ready = 1'b1;
        step();
        chk("t3_next_port3", 64'(dout_addr), 64'(3));
        din_en = 4'b0001;
        step();
        chk("t3_then_port0", 64'(dout_addr), 64'(0));
        din_en = 4'b0;
        step();

        // One word then idle: stage drains and zeroes
        din_en = 4'b0001;
        din[0] = 32'h0000_00AB;
        step();
        chk("t4_full", 64'(dout_en), 64'(1));
        din_en = 4'b0;
        step();
        chk("t4_empty", 64'({dout_en, dout_addr, dout}), 64'(0));

        // Asynchronous reset while holding a word
        din_en = 4'b0001;
        din[0] = 32'hDEAD_BEEF;
        dout_ready = 1'b0;
        step();
        chk("t5_loaded", 64'(dout), 64'(32'hDEAD_BEEF));
        din_en = 4'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_async_clear", 64'({dout_en, dout_addr, dout}), 64'(0));
        model_reset();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = DW'(32'h5000_0000 + i);
        din_en = 4'b1111;
        dout_ready = 1'b1;
        step();
        chk("t5_first_grant", 64'(dout_addr), 64'(0));
        din_en = 4'b0;
        step();

        // Randomized traffic; data encodes source and per-source sequence
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            din[i] = {2'(i), 30'(seq[i])};
            din_en[i] = 1'($urandom_range(0, 1));
        end
        dout_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    din[i] = {2'(i), 30'(seq[i])};
                    din_en[i] = ($urandom_range(0, 3) != 0);
                end else if (!din_en[i]) begin
                    din_en[i] = 1'($urandom_range(0, 1));
                end
            end
            dout_ready = ($urandom_range(0, 3) != 0);
        end
        din_en = 4'b0;
        dout_ready = 1'b1;
        repeat (3) step();
        chk("drain_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
